// File: rtl/elastic_pipe.sv
// DEPTH-stage valid/ready register chain with bubble collapsing, flush-to-NOP and occupancy count.
// Latency DEPTH cycles on an empty pipe; a stage loads whenever it or any stage ahead of it is empty, so ready_o drops only when full and stalled.
module elastic_pipe #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 4,
    parameter int CLEAR_DATA = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_n,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [WIDTH-1:0]           data_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [WIDTH-1:0]           data_o,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] en;
    logic [DEPTH-1:0] src_v;
    logic [WIDTH-1:0] d     [DEPTH];
    logic [WIDTH-1:0] src_d [DEPTH];
    logic             tail_full;
    logic             in_xfer;
    logic             out_xfer;

    // en[k] is low only when stages k..DEPTH-1 are all valid and the output is stalled.
    always_comb begin
        tail_full = 1'b1;
        en        = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            tail_full = tail_full & v[k];
            en[k]     = ready_i | ~tail_full;
        end
    end

    assign ready_o  = en[0] & ~flush_i;
    assign valid_o  = v[DEPTH-1] & ~flush_i;
    assign data_o   = d[DEPTH-1];
    assign in_xfer  = valid_i & ready_o;
    assign out_xfer = valid_o & ready_i;

    always_comb begin
        src_v    = '0;
        src_v[0] = in_xfer;
        src_d[0] = data_i;
        for (int k = 1; k < DEPTH; k++) begin
            src_v[k] = v[k-1];
            src_d[k] = d[k-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            v       <= '0;
            count_o <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                d[k] <= '0;
            end
        end else if (flush_i) begin
            v       <= '0;
            count_o <= '0;
            if (CLEAR_DATA != 0) begin
                for (int k = 0; k < DEPTH; k++) begin
                    d[k] <= '0;
                end
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (en[k]) begin
                    v[k] <= src_v[k];
                    if (src_v[k]) begin
                        d[k] <= src_d[k];
                    end else if (CLEAR_DATA != 0) begin
                        d[k] <= '0;
                    end
                end
            end
            count_o <= count_o + CW'(in_xfer) - CW'(out_xfer);
        end
    end

endmodule

// File: tb/tb_elastic_pipe.sv
// Randomized and directed bench for elastic_pipe: two instances (clearing and holding data) against a slot model plus an in-order scoreboard.
module tb_elastic_pipe;

    localparam int D = 4;
    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         rst_n;
    logic         valid_i;
    logic [W-1:0] data_i;
    logic         ready_i;
    logic         flush_i;
    logic         ready_o, valid_o;
    logic [W-1:0] data_o;
    logic [2:0]   count_o;
    logic         ready_h, valid_h;
    logic [W-1:0] data_h;
    logic [2:0]   count_h;

    int checks = 0;
    int errors = 0;

    // Reference: slot occupancy/content per instance (0 = clearing, 1 = holding) and the in-flight item queue.
    logic         mv [D];
    logic [W-1:0] md [2][D];
    logic [W-1:0] q  [$];
    int           n_out = 0;

    always #5 clk_i = ~clk_i;

    elastic_pipe #(.WIDTH(W), .DEPTH(D), .CLEAR_DATA(1)) u_dut (
        .clk_i(clk_i), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .flush_i(flush_i), .count_o(count_o)
    );

    elastic_pipe #(.WIDTH(W), .DEPTH(D), .CLEAR_DATA(0)) u_hold (
        .clk_i(clk_i), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_h), .data_i(data_i),
        .valid_o(valid_h), .ready_i(ready_i), .data_o(data_h), .flush_i(flush_i), .count_o(count_h)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < D; k++) begin
            mv[k]    = 1'b0;
            md[0][k] = '0;
            md[1][k] = '0;
        end
        q.delete();
    endtask

    // Items collapse toward the output: only a solid run of valid slots at the output end stalls, and only while ready_i is low.
    function automatic int hold_from();
        int hf = D;
        if (!ready_i) begin
            for (int k = D - 1; k >= 0; k--) begin
                if (mv[k]) hf = k;
                else break;
            end
        end
        return hf;
    endfunction

    task automatic model_step(input int hf);
        logic in_x, out_x;
        if (flush_i) begin
            for (int k = 0; k < D; k++) begin
                mv[k]    = 1'b0;
                md[0][k] = '0;
            end
            q.delete();
            return;
        end
        in_x  = valid_i && (hf > 0);
        out_x = mv[D-1] && ready_i;
        if (out_x) begin
            n_out++;
            if (q.size() > 0) void'(q.pop_front());
        end
        if (in_x) q.push_back(data_i);
        for (int k = hf - 1; k >= 1; k--) begin
            for (int c = 0; c < 2; c++) begin
                if (mv[k-1])     md[c][k] = md[c][k-1];
                else if (c == 0) md[c][k] = '0;
            end
            mv[k] = mv[k-1];
        end
        if (hf > 0) begin
            for (int c = 0; c < 2; c++) begin
                if (in_x)        md[c][0] = data_i;
                else if (c == 0) md[c][0] = '0;
            end
            mv[0] = in_x;
        end
    endtask

    task automatic cyc(input logic v, input logic [W-1:0] dat, input logic r, input logic f,
                       output logic acc);
        int   hf;
        logic ev;
        valid_i = v;
        data_i  = dat;
        ready_i = r;
        flush_i = f;
        #1;
        hf = hold_from();
        ev = mv[D-1] && !f;
        chk("ready", ready_o, (hf > 0) && !f);
        chk("valid", valid_o, ev);
        chk("data", data_o, md[0][D-1]);
        chk("count", count_o, q.size());
        chk("valid_hold", valid_h, ev);
        chk("data_hold", data_h, md[1][D-1]);
        if (ev && r && q.size() > 0) chk("order", data_o, q[0]);
        acc = ready_o & valid_i;
        model_step(hf);
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    logic acc;
    int   lat;
    int   idx;
    int   base;

    initial begin
        rst_n   = 1'b0;
        valid_i = 1'b0;
        data_i  = '0;
        ready_i = 1'b1;
        flush_i = 1'b0;
        model_reset();
        #2;
        chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_ready", ready_o, 1);
        @(negedge clk_i);
        rst_n = 1'b1;

        // Stream 0x11..0x55 and measure fill latency.
        lat = -1;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 32'h11 * (i + 1), 1'b1, 1'b0, acc);
            if (lat < 0 && valid_o) lat = i + 1;
        end
        chk("latency", lat, D);
        for (int i = 0; i < 6; i++) cyc(1'b0, $urandom, 1'b1, 1'b0, acc);

        // Stalled output: A1..A4 compress in, A5/A6 wait, then everything drains in order.
        idx  = 0;
        base = n_out;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 32'hA1 + idx, 1'b0, 1'b0, acc);
            if (acc) idx++;
        end
        chk("stall_accepts", idx, 4);
        chk("stall_count", count_o, 4);
        chk("stall_data", data_o, 32'hA1);
        chk("stall_ready", ready_o, 0);
        for (int i = 0; i < 20 && idx < 6; i++) begin
            cyc(1'b1, 32'hA1 + idx, 1'b1, 1'b0, acc);
            if (acc) idx++;
        end
        for (int i = 0; i < 8; i++) cyc(1'b0, $urandom, 1'b1, 1'b0, acc);
        chk("stall_emitted", n_out - base, 6);

        // Full pass-through.
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'hB0 + i, 1'b0, 1'b0, acc);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 32'hC0 + i, 1'b1, 1'b0, acc);
            chk("thru_acc", acc, 1);
            chk("thru_count", count_o, 4);
        end
        for (int i = 0; i < 6; i++) cyc(1'b0, $urandom, 1'b1, 1'b0, acc);

        // Flush with three items held and a competing input.
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h100 + i, 1'b0, 1'b0, acc);
        cyc(1'b1, 32'hDEAD, 1'b1, 1'b1, acc);
        chk("flush_acc", acc, 0);
        chk("flush_count", count_o, 0);
        chk("flush_data", data_o, 0);
        for (int i = 0; i < 6; i++) cyc(1'b0, $urandom, 1'b1, 1'b0, acc);

        // Alternating input creates bubbles; the holding instance repeats the prior item.
        for (int i = 0; i < 12; i++) cyc(i % 2 == 0, 32'hE0 + i, 1'b1, 1'b0, acc);
        for (int i = 0; i < 6; i++) cyc(1'b0, $urandom, 1'b1, 1'b0, acc);

        // Asynchronous reset with three items in flight.
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h300 + i, 1'b0, 1'b0, acc);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", valid_o, 0);
        chk("arst_data", data_o, 0);
        chk("arst_count", count_o, 0);
        chk("arst_data_hold", data_h, 0);
        model_reset();
        @(negedge clk_i);
        rst_n = 1'b1;
        cyc(1'b1, 32'h77, 1'b1, 1'b0, acc);
        lat = 1;
        while (!valid_o && lat < 10) begin
            cyc(1'b0, $urandom, 1'b1, 1'b0, acc);
            lat++;
        end
        chk("latency_77", lat, D);
        chk("out_77", data_o, 32'h77);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
                $urandom_range(0, 29) == 0, acc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
